// File: rtl/decoder_3to8_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : decoder_3to8_sequencer
// Purpose : Buffers 3-bit codes and drives each as a one-hot word for HOLD_CYCLES.
//           Optional macro DEC_GAP_CYCLE_EN inserts one idle cycle after each code.
// Rev     : 1.0  initial release
// ============================================================================
module decoder_3to8_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] code_in,
  input  logic       code_valid,
  output logic       code_ready,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       busy,
  output logic       done
);

  localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w  = $clog2(FIFO_DEPTH + 1);
  localparam int c_hold_w = $clog2(HOLD_CYCLES + 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_full    = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0]  c_cnt_one     = c_cnt_w'(1);
  localparam logic [c_hold_w-1:0] c_hold_reload = c_hold_w'(HOLD_CYCLES - 1);
  localparam logic [c_hold_w-1:0] c_hold_one    = c_hold_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  logic [2:0]          mem_q [FIFO_DEPTH];
  logic [c_ptr_w-1:0]  wr_ptr_q, rd_ptr_q;
  logic [c_cnt_w-1:0]  count_q;
  state_t              state_q, state_d;
  logic [c_hold_w-1:0] hold_q, hold_d;
  logic [7:0]          out_q, out_d;

  logic       w_empty, w_full, w_push, w_pop;
  logic [2:0] w_head;

  assign w_empty    = (count_q == '0);
  assign w_full     = (count_q == c_cnt_full);
  assign code_ready = !w_full;
  assign w_push     = code_valid && !w_full;
  assign w_head     = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= code_in;
  end

  // Pointers wrap for free because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      out_q    <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + c_cnt_one;
        2'b01:   count_q <= count_q - c_cnt_one;
        default: count_q <= count_q;
      endcase
      state_q <= state_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    out_d   = out_q;
    w_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        out_d = '0;
        w_pop = !w_empty;
      end
      ST_HOLD: begin
        if (hold_q != '0) begin
          hold_d = hold_q - c_hold_one;
        end else begin
`ifdef DEC_GAP_CYCLE_EN
          out_d   = '0;
          state_d = ST_GAP;
`else
          out_d   = '0;
          state_d = ST_IDLE;
          w_pop   = !w_empty;
`endif
        end
      end
`ifdef DEC_GAP_CYCLE_EN
      ST_GAP: begin
        out_d   = '0;
        state_d = ST_IDLE;
        w_pop   = !w_empty;
      end
`endif
      default: begin
        out_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    // Any pop loads the head word and restarts the hold, overriding the idle path.
    if (w_pop) begin
      out_d   = 8'h01 << w_head;
      hold_d  = c_hold_reload;
      state_d = ST_HOLD;
    end
  end

  assign out       = out_q;
  assign out_valid = (out_q != 8'h00);
  assign done      = (state_q == ST_HOLD) && (hold_q == '0);
  assign busy      = (state_q != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_decoder_3to8_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_decoder_3to8_sequencer
// Purpose : Randomized bench with a schedule-based model of code start times.
// Rev     : 1.0  initial release
// ============================================================================
module tb_decoder_3to8_sequencer;

  localparam int DEPTH = 4;
  localparam int HOLD  = 3;
`ifdef DEC_GAP_CYCLE_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] code_in = 3'd0;
  logic       code_valid = 1'b0;
  logic       code_ready, out_valid, busy, done;
  logic [7:0] out;

  decoder_3to8_sequencer #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .code_ready(code_ready), .out(out), .out_valid(out_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // cyc == number of rising edges seen; cycle t is the interval after edge t.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: each accepted code k has accept edge a, start cycle s; it shows on
  // out during cycles s..s+HOLD-1 and leaves the FIFO at edge s.
  int         q_a[$];
  int         q_s[$];
  logic [2:0] q_c[$];
  int         next_free = 0;

  function automatic int cnt_after(input int t);
    int n = 0;
    foreach (q_a[i]) begin
      if (q_a[i] <= t) n++;
      if (q_s[i] <= t) n--;
    end
    return n;
  endfunction

  // Packed as {out, out_valid, done, busy, code_ready}.
  function automatic logic [11:0] exp_vec(input int t);
    logic [7:0] o = 8'h00;
    logic d = 1'b0, act = 1'b0;
    int n = cnt_after(t);
    foreach (q_s[i]) begin
      if (t >= q_s[i] && t < q_s[i] + HOLD) o = 8'h01 << q_c[i];
      if (t == q_s[i] + HOLD - 1) d = 1'b1;
      if (t >= q_s[i] && t < q_s[i] + HOLD + GAP) act = 1'b1;
    end
    return {o, (o != 8'h00), d, (act || n != 0), (n < DEPTH)};
  endfunction

  task automatic model_clear();
    q_a.delete(); q_s.delete(); q_c.delete();
    next_free = 0;
  endtask

  task automatic drive(input logic v, input logic [2:0] c, output logic acc);
    code_valid = v;
    code_in    = c;
    acc = v && (cnt_after(cyc) < DEPTH);
    if (acc) begin
      int a, s;
      a = cyc + 1;
      s = (a + 1 > next_free) ? a + 1 : next_free;
      q_a.push_back(a); q_s.push_back(s); q_c.push_back(c);
      next_free = s + HOLD + GAP;
    end
  endtask

  task automatic test_reset();
    logic [11:0] got, exp;
    rst = 1'b1; code_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    got = {out, out_valid, done, busy, code_ready};
    n_checks++;
    if (got !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_state got=%h exp=%h", got, {8'h00, 4'b0001});
    else n_pass++;
    repeat (3) begin
      @(negedge clk);
      got = {out, out_valid, done, busy, code_ready}; exp = exp_vec(cyc);
      n_checks++;
      if (got !== exp) $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_single_code();
    logic [11:0] got, exp;
    logic acc;
    int n0, rel;
    @(negedge clk);
    n0 = cyc + 1;
    drive(1'b1, 3'd5, acc);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rel = cyc - n0;
      got = {out, out_valid, done, busy, code_ready}; exp = exp_vec(cyc);
      n_checks++;
      if (got !== exp) $display("FAIL single_model cyc=%0d got=%h exp=%h", cyc, got, exp);
      else n_pass++;
      n_checks++;
      if ({out, done} !== {((rel >= 1 && rel <= 3) ? 8'h20 : 8'h00), (rel == 3)})
        $display("FAIL single_const rel=%0d out=%h done=%b", rel, out, done);
      else n_pass++;
      drive(1'b0, 3'd0, acc);
    end
  endtask

  task automatic test_walk_codes();
    logic [11:0] got, exp;
    logic acc, saw_full;
    int sent, dones;
    sent = 0; dones = 0; saw_full = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      got = {out, out_valid, done, busy, code_ready}; exp = exp_vec(cyc);
      n_checks++;
      if (got !== exp) $display("FAIL walk_model cyc=%0d got=%h exp=%h", cyc, got, exp);
      else n_pass++;
      if (done) dones++;
      if (!code_ready) saw_full = 1'b1;
      if (sent < 8) begin
        drive(1'b1, 3'(sent), acc);
        if (acc) sent++;
      end else drive(1'b0, 3'd0, acc);
    end
    n_checks++;
    if (dones != 8 || sent != 8) $display("FAIL walk_counts dones=%0d sent=%0d exp=8", dones, sent);
    else n_pass++;
    n_checks++;
    if (!saw_full) $display("FAIL walk_full code_ready never dropped exp=drop");
    else n_pass++;
  endtask

  task automatic test_full_fifo();
    logic [11:0] got, exp;
    logic acc;
    logic [2:0] pushed[$];
    logic [2:0] c;
    int sent;
    sent = 0;
    c = 3'($urandom_range(0, 7));
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      got = {out, out_valid, done, busy, code_ready}; exp = exp_vec(cyc);
      n_checks++;
      if (got !== exp) $display("FAIL full_model cyc=%0d got=%h exp=%h", cyc, got, exp);
      else n_pass++;
      if (done) begin
        n_checks++;
        if (pushed.size() == 0) $display("FAIL full_order extra done out=%h", out);
        else if (out !== (8'h01 << pushed[0])) $display("FAIL full_order out=%h exp=%h", out, 8'h01 << pushed[0]);
        else n_pass++;
        if (pushed.size() != 0) void'(pushed.pop_front());
      end
      if (sent < 5) begin
        drive(1'b1, c, acc);
        if (acc) begin
          pushed.push_back(c);
          sent++;
          c = 3'($urandom_range(0, 7));
        end
      end else drive(1'b0, 3'd0, acc);
    end
    n_checks++;
    if (sent != 5 || pushed.size() != 0) $display("FAIL full_drain sent=%0d left=%0d exp=5/0", sent, pushed.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [11:0] got, exp;
    logic acc, found;
    logic [2:0] list [4];
    int sent;
    list = '{3'd2, 3'd0, 3'd1, 3'd6};
    sent = 0; found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      got = {out, out_valid, done, busy, code_ready}; exp = exp_vec(cyc);
      n_checks++;
      if (got !== exp) $display("FAIL rstmid_model cyc=%0d got=%h exp=%h", cyc, got, exp);
      else n_pass++;
      if (out == 8'h04 && cnt_after(cyc) >= 2) found = 1'b1;
      else if (sent < 4) begin
        drive(1'b1, list[sent], acc);
        if (acc) sent++;
      end else drive(1'b0, 3'd0, acc);
    end
    n_checks++;
    if (!found) $display("FAIL rstmid_wait out=%h exp=04 with queued codes", out);
    else n_pass++;
    rst = 1'b1; code_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    got = {out, out_valid, done, busy, code_ready};
    n_checks++;
    if (got !== {8'h00, 4'b0001}) $display("FAIL rstmid_state got=%h exp=%h", got, {8'h00, 4'b0001});
    else n_pass++;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_checks++;
      if ({out, busy} !== 9'h000) $display("FAIL rstmid_flush cyc=%0d out=%h busy=%b exp=00/0", cyc, out, busy);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [11:0] got, exp;
    logic acc, v;
    for (int k = 0; k < 340; k++) begin
      @(negedge clk);
      got = {out, out_valid, done, busy, code_ready}; exp = exp_vec(cyc);
      n_checks++;
      if (got !== exp) $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, got, exp);
      else n_pass++;
      v = (k < 300) && ($urandom_range(0, 99) < (((k / 50) % 2 == 0) ? 85 : 25));
      drive(v, 3'($urandom_range(0, 7)), acc);
    end
  endtask

`ifdef DEC_GAP_CYCLE_EN
  task automatic test_gap();
    logic acc;
    logic [7:0] eo;
    int n0, rel;
    @(negedge clk);
    n0 = cyc + 1;
    drive(1'b1, 3'd2, acc);
    @(negedge clk);
    drive(1'b1, 3'd2, acc);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(1'b0, 3'd0, acc);
      rel = cyc - n0;
      eo = ((rel >= 1 && rel <= 3) || (rel >= 5 && rel <= 7)) ? 8'h04 : 8'h00;
      n_checks++;
      if (out !== eo) $display("FAIL gap_seq rel=%0d out=%h exp=%h", rel, out, eo);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_code();
    test_walk_codes();
    test_full_fifo();
    test_reset_mid();
    test_random();
`ifdef DEC_GAP_CYCLE_EN
    test_gap();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
